// File: rtl/calc_engine.sv
// calc_engine: byte-stream expression evaluator driving the UART register port.
//
// Parses "A op B =" from bytes received through the UART (digits as raw
// values 0..9, operators '+', '-', '*' in ASCII, '=' to evaluate) and sends
// the 16-bit result back through the UART transmitter, high byte first.
// A malformed expression sends ERR_CODE twice instead.
//
// Ports:
//   clk       system clock, shared with the UART
//   rst_n     asynchronous active-low reset
//   address   UART register address (0 RX data, 1 status, 2 TX data)
//   w_data    UART write data
//   we        UART write strobe, one cycle
//   r_data    UART read data for the current address
//   result    last evaluated result, held until the next '='
//   done      one-cycle pulse when the last result byte is written
//   overflow  last result did not fit in 16 bits
//   error     last expression was malformed
module calc_engine #(
    parameter logic [7:0] ERR_CODE = 8'hEE
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [2:0]  address,
    output logic [7:0]  w_data,
    output logic        we,
    input  logic [7:0]  r_data,
    output logic [15:0] result,
    output logic        done,
    output logic        overflow,
    output logic        error
);

    typedef enum logic [3:0] {
        POLL_RX, READ, ACK, PARSE, EXEC, TXW_HI, TX_HI, TXW_LO, TX_LO
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [2:0] ADDR_RX     = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_TX     = 3'd2;

    state_t      state, state_nxt;
    logic [7:0]  byte_reg;
    logic [15:0] acc_a, acc_b;
    logic [1:0]  op;
    logic        have_op;
    logic        ovf;

    logic        is_digit, is_op, is_eq, is_bad;
    logic [1:0]  op_code;
    logic [16:0] step_a, step_b, eval_res;

    // Decimal shift-in: acc*10 + d computed 20 bits wide; bit 16 of the
    // return flags any nonzero bits lost by truncating to 16.
    function automatic logic [16:0] digit_step(input logic [15:0] acc,
                                               input logic [3:0]  d);
        logic [19:0] p;
        p = ({4'd0, acc} * 20'd10) + {16'd0, d};
        return {|p[19:16], p[15:0]};
    endfunction

    // Evaluate A op B; bit 16 of the return is the overflow indication.
    function automatic logic [16:0] evaluate(input logic [15:0] a,
                                             input logic [15:0] b,
                                             input logic [1:0]  code,
                                             input logic        with_op);
        logic [16:0] sum;
        logic [31:0] prod;
        logic [16:0] r;
        sum  = {1'b0, a} + {1'b0, b};
        prod = {16'd0, a} * {16'd0, b};
        r    = {1'b0, a};
        if (with_op) begin
            case (code)
                OP_ADD:  r = sum;
                OP_SUB:  r = {(a < b), a - b};
                OP_MUL:  r = {|prod[31:16], prod[15:0]};
                default: r = {1'b0, a};
            endcase
        end
        return r;
    endfunction

    // Byte classification of the captured byte.
    always_comb begin
        is_digit = (byte_reg <= 8'd9);
        is_eq    = (byte_reg == 8'h3D);
        is_op    = 1'b0;
        op_code  = OP_ADD;
        case (byte_reg)
            8'h2B: begin is_op = 1'b1; op_code = OP_ADD; end
            8'h2D: begin is_op = 1'b1; op_code = OP_SUB; end
            8'h2A: begin is_op = 1'b1; op_code = OP_MUL; end
            default: ;
        endcase
        // A second operator is as malformed as an unknown byte.
        is_bad = !(is_digit || is_op || is_eq) || (is_op && have_op);
    end

    assign step_a   = digit_step(acc_a, byte_reg[3:0]);
    assign step_b   = digit_step(acc_b, byte_reg[3:0]);
    assign eval_res = evaluate(acc_a, acc_b, op, have_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= POLL_RX;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and bus outputs. The status register is addressed by
    // default so rx_valid / tx_busy are visible in the polling states.
    always_comb begin
        state_nxt = state;
        address   = ADDR_STATUS;
        w_data    = 8'd0;
        we        = 1'b0;
        done      = 1'b0;
        case (state)
            POLL_RX: if (r_data[0]) state_nxt = READ;
            READ: begin
                address   = ADDR_RX;
                state_nxt = ACK;
            end
            ACK: begin
                // Any status write clears rx_valid.
                we        = 1'b1;
                state_nxt = PARSE;
            end
            PARSE: begin
                if (is_bad)     state_nxt = TXW_HI;
                else if (is_eq) state_nxt = EXEC;
                else            state_nxt = POLL_RX;
            end
            EXEC:   state_nxt = TXW_HI;
            TXW_HI: if (!r_data[1]) state_nxt = TX_HI;
            TX_HI: begin
                address   = ADDR_TX;
                we        = 1'b1;
                w_data    = error ? ERR_CODE : result[15:8];
                state_nxt = TXW_LO;
            end
            TXW_LO: if (!r_data[1]) state_nxt = TX_LO;
            TX_LO: begin
                address   = ADDR_TX;
                we        = 1'b1;
                w_data    = error ? ERR_CODE : result[7:0];
                done      = 1'b1;
                state_nxt = POLL_RX;
            end
            default: state_nxt = POLL_RX;
        endcase
    end

    // Expression registers and held outputs. The held error flag also
    // selects ERR_CODE during the transmit that follows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_reg <= 8'd0;
            acc_a    <= 16'd0;
            acc_b    <= 16'd0;
            op       <= OP_ADD;
            have_op  <= 1'b0;
            ovf      <= 1'b0;
            result   <= 16'd0;
            overflow <= 1'b0;
            error    <= 1'b0;
        end else begin
            case (state)
                READ: byte_reg <= r_data;
                PARSE: begin
                    if (is_bad) begin
                        error    <= 1'b1;
                        overflow <= 1'b0;
                    end else if (is_digit) begin
                        if (have_op) begin
                            acc_b <= step_b[15:0];
                            ovf   <= ovf | step_b[16];
                        end else begin
                            acc_a <= step_a[15:0];
                            ovf   <= ovf | step_a[16];
                        end
                    end else if (is_op) begin
                        op      <= op_code;
                        have_op <= 1'b1;
                    end
                end
                EXEC: begin
                    result   <= eval_res[15:0];
                    overflow <= ovf | eval_res[16];
                    error    <= 1'b0;
                end
                TX_LO: begin
                    acc_a   <= 16'd0;
                    acc_b   <= 16'd0;
                    have_op <= 1'b0;
                    ovf     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/calc_engine.md
# calc_engine

Byte-stream expression evaluator that sits directly downstream of the `UART` block on its register bus. It polls the UART for received bytes and parses decimal digits (raw values 0–9) and one ASCII operator into `A op B`. On `=` it evaluates the expression and writes the 16-bit result back through the UART transmitter, high byte first. `calc_engine` is the sole bus master of the `UART` register port.

## Interface
Parameters:
- `ERR_CODE`, default 8'hEE: byte transmitted twice when the expression is malformed.

Ports:
- `clk`  in  1  system clock, shared with `UART`.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `address`  out  3  UART register address.
- `w_data`  out  8  UART write data.
- `we`  out  1  UART write enable, one-cycle pulse.
- `r_data`  in  8  UART read data; combinational for the current `address`.
- `result`  out  16  last evaluated result, held until the next `=`.
- `done`  out  1  one-cycle pulse when the last result byte is written.
- `overflow`  out  1  last result did not fit in 16 bits; held.
- `error`  out  1  last expression was malformed; held.

UART register map:
- addr 0: RX data, read-only.
- addr 1: status; bit0 = rx_valid, bit1 = tx_busy. Any write clears rx_valid.
- addr 2: TX data; a write starts transmission.

## Operation
- Input byte classes:
  - digit 0x00–0x09.
  - `+` 0x2B, `-` 0x2D, `*` 0x2A.
  - `=` 0x3D.
  - any other byte is illegal.
- Registers: `acc_a`[15:0], `acc_b`[15:0], `op`[1:0], `have_op`, `ovf`.
- Digit handling:
  - Before an operator, `acc_a <= acc_a*10 + d`; after it, the same update is applied to `acc_b`.
  - The product is computed 20 bits wide and truncated to 16 bits.
  - Any nonzero truncated bits set `ovf`.
- Operator handling:
  - If `have_op==0`: latch `op`, set `have_op`.
  - If `have_op==1`: error.
- `=` handling:
  - `+`: 17-bit sum; bit16 sets `ovf`.
  - `-`: 16-bit wrap; A<B sets `ovf`.
  - `*`: 32-bit product; nonzero upper half sets `ovf`. `result` takes the low 16 bits.
  - No operator: `result = acc_a`.
- Error (illegal byte or second operator): `error <= 1`, then transmit `ERR_CODE` twice, skip evaluation, leave `result` unchanged.
- After the transmit sequence:
  - Clear `acc_a`, `acc_b`, `have_op`, `ovf`.
  - `error` and `overflow` are updated on each `=` or error and otherwise held.
  - `done` pulses in both cases.
- FSM states: POLL_RX, READ, ACK, PARSE, EXEC, TXW_HI, TX_HI, TXW_LO, TX_LO.
  - POLL_RX: `address=1`; when rx_valid=1, go to READ.
  - READ: `address=0`; capture `r_data` into the byte register.
  - ACK: `address=1`, `we=1`, `w_data=0`.
  - PARSE: digit or operator returns to POLL_RX; `=` goes to EXEC; illegal byte goes to TXW_HI with error.
  - EXEC: register `result` and flags, then go to TXW_HI.
  - TXW_HI: `address=1`; wait while tx_busy=1.
  - TX_HI: `address=2`, `we=1`, `w_data=result[15:8]` (or `ERR_CODE`).
  - TXW_LO: same as TXW_HI.
  - TX_LO: write `result[7:0]` (or `ERR_CODE`), pulse `done`, return to POLL_RX.
- No RX polling during TX states. Bytes arriving meanwhile remain pending in the UART (overrun is the UART's concern).

## Timing
- Reset values:
  - Outputs: `address=1`, `w_data=0`, `we=0`, `result=0`, `done=0`, `overflow=0`, `error=0`.
  - Internals: all accumulators 0; state POLL_RX.
- Minimum 4 cycles per received byte (POLL_RX→READ→ACK→PARSE); rx_valid is sampled in the same cycle `address=1`.
- `=` accepted to TX_HI write: 3 cycles when tx_busy=0.
- `we` is asserted only in ACK, TX_HI and TX_LO, always for exactly one cycle.
- `result`, `overflow` and `error` change only on the cycle leaving EXEC or PARSE(error).
- `rst_n` low at any point, including mid-transmit:
  - Immediate return to reset values.
  - A partial expression is discarded.
  - No further `we`.

## Test plan
- Bytes 08,07,2A,09,03,3D → TX 0x1F then 0x9B; `result=8091`, `overflow=0`, one `done` pulse.
- Bytes 01,02,2B,03,00,3D → TX 0x00,0x2A; `result=42`.
- Bytes 05,2D,09,3D → `result=0xFFFC`, `overflow=1`.
- Bytes 03,00,00,2A,03,00,00,3D → `result=0x5F90` (90000 mod 65536), `overflow=1`.
- Bytes 04,41 → `error=1`, TX 0xEE,0xEE; `result` unchanged. The next expression 02,2A,03,3D gives `result=6`, `error=0`.
- tx_busy held 1 for 50 cycles at `=` → no `we` until it drops. `rst_n` pulsed low after bytes 09,2B → all outputs at reset values; then 02,3D yields `result=2`.
